mc_control_fsm: RTL and testbench

Multicycle control unit for the ARM-subset processor. It decodes Instr[31:12] over several clock cycles and drives a datapath that shares one memory and one ALU between instruction fetch, address generation and execution. The block holds the main state machine, the NZCV flag registers and the latched condition-pass bit. It sits between the instruction register and the multicycle datapath and replaces the single-cycle controller in multicycle builds.

---
 rtl/mc_ctrl_pkg.sv | 55 +++++
 rtl/cond_check.sv | 38 +++
 rtl/mc_control_fsm.sv | 162 ++++++++++++++++
 tb/tb_mc_control_fsm.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit:
// state codes, ALU operations, datapath mux selects and condition codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctl_t;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_RDATA   = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;

  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/cond_check.sv
// Evaluates an ARM condition code against the NZCV flag registers.
// Latency: combinational. Backpressure: none.
// Code 1111 never passes.
module cond_check
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condex
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    condex = 1'b0;
    case (cond)
      COND_EQ: condex = z;
      COND_NE: condex = ~z;
      COND_CS: condex = c;
      COND_CC: condex = ~c;
      COND_MI: condex = n;
      COND_PL: condex = ~n;
      COND_VS: condex = v;
      COND_VC: condex = ~v;
      COND_HI: condex = c & ~z;
      COND_LS: condex = ~c | z;
      COND_GE: condex = (n == v);
      COND_LT: condex = (n != v);
      COND_GT: condex = ~z & (n == v);
      COND_LE: condex = z | (n != v);
      COND_AL: condex = 1'b1;
      COND_NV: condex = 1'b0;
      default: condex = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control unit: main FSM, ALU decode, NZCV flags and latched condition pass.
// Latency: 2-5 cycles per instruction (FETCH included); outputs are a function of state and Instr.
// Backpressure: none; the instruction stream advances one state per clock.
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [3:0]  State
);

  logic [3:0] cond, rn, rd;
  logic [1:0] op;
  logic [5:0] funct;
  assign {cond, op, funct, rn, rd} = Instr;

  logic unused_rn;
  assign unused_rn = ^rn;

  state_t     state_q, state_d, dec_state;
  logic [3:0] flags_q;
  logic       condex, condex_q;
  logic       next_pc, branch, reg_w, mem_w, ir_w, alu_op, pcs;
  logic [1:0] flag_w;
  alu_ctl_t   alu_ctl;

  cond_check u_cond_check (
    .cond   (cond),
    .flags  (flags_q),
    .condex (condex)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE)
        condex_q <= condex;
      // alu_op is only ever high in EXECR/EXECI, so flags cannot move elsewhere
      if (alu_op && flag_w[1] && condex_q)
        flags_q[3:2] <= ALUFlags[3:2];
      if (alu_op && flag_w[0] && condex_q)
        flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   state_d = S_BRANCH;
          OP_NOP:  state_d = S_FETCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // While reset is held the datapath sees the FETCH mux encoding.
  assign dec_state = reset ? state_q : S_FETCH;

  always_comb begin
    next_pc   = 1'b0;
    branch    = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    ir_w      = 1'b0;
    alu_op    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RD2;
    ResultSrc = RES_ALUOUT;
    case (dec_state)
      S_FETCH: begin
        ir_w      = 1'b1;
        next_pc   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
      end
      S_MEMADR: ALUSrcB = SRCB_EXTIMM;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_RDATA;
        reg_w     = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      S_EXECR:  alu_op = 1'b1;
      S_EXECI: begin
        ALUSrcB = SRCB_EXTIMM;
        alu_op  = 1'b1;
      end
      S_ALUWB:  reg_w = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = SRCB_EXTIMM;
        ResultSrc = RES_ALURES;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // Unrecognised commands fall back to add with both flag groups held.
  always_comb begin
    alu_ctl = ALU_ADD;
    flag_w  = 2'b00;
    if (alu_op) begin
      case (funct[4:1])
        4'b0100: begin alu_ctl = ALU_ADD; flag_w = {2{funct[0]}};     end
        4'b0010: begin alu_ctl = ALU_SUB; flag_w = {2{funct[0]}};     end
        4'b0000: begin alu_ctl = ALU_AND; flag_w = {funct[0], 1'b0}; end
        4'b1100: begin alu_ctl = ALU_ORR; flag_w = {funct[0], 1'b0}; end
        default: ;
      endcase
    end
  end

  assign ALUControl = alu_ctl;
  assign ImmSrc     = op;
  assign RegSrc     = {op == OP_MEM, op == OP_BR};

  assign pcs      = ((rd == 4'hF) & reg_w) | branch;
  assign PCWrite  = reset & (next_pc | (pcs & condex_q));
  assign IRWrite  = reset & ir_w;
  assign RegWrite = reset & reg_w & condex_q;
  assign MemWrite = reset & mem_w & condex_q;
  assign State    = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-cycle expected outputs are queued with the stimulus
// and compared as the FSM walks each instruction.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] Instr = 20'h0;
  logic [3:0]  ALUFlags = 4'h0;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0]  State;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .RegWrite   (RegWrite),
    .State      (State)
  );

  // wr = {PCWrite, IRWrite, RegWrite, MemWrite}; mux = {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB}
  typedef struct packed {
    logic [3:0] st;
    logic [3:0] wr;
    logic [5:0] mux;
    logic [1:0] alu;
  } obs_t;

  typedef struct packed {
    logic        rst;
    logic [19:0] ins;
    logic [3:0]  af;
  } stim_t;

  obs_t  sb[$];
  stim_t stq[$];
  int    total = 0;
  int    bad = 0;

  // Mux selects each state presents to the datapath.
  function automatic logic [5:0] mux_of(input logic [3:0] st);
    case (st)
      4'd0, 4'd1: mux_of = 6'b0_10_1_10;
      4'd2:       mux_of = 6'b0_00_0_01;
      4'd3, 4'd5: mux_of = 6'b1_00_0_00;
      4'd4:       mux_of = 6'b0_01_0_00;
      4'd7:       mux_of = 6'b0_00_0_01;
      4'd9:       mux_of = 6'b0_10_0_01;
      default:    mux_of = 6'b0_00_0_00;
    endcase
  endfunction

  task automatic push(input logic rst, input logic [19:0] ins, input logic [3:0] af,
                      input logic [3:0] st, input logic [3:0] mst,
                      input logic [3:0] wr, input logic [1:0] alu);
    stim_t s;
    obs_t  e;
    s = '{rst: rst, ins: ins, af: af};
    e = '{st: st, wr: wr, mux: mux_of(mst), alu: alu};
    stq.push_back(s);
    sb.push_back(e);
  endtask

  // Data-processing: FETCH, DECODE, EXECx, ALUWB.
  task automatic dp(input logic [19:0] ins, input logic [3:0] af, input logic [3:0] exst,
                    input logic [1:0] alu, input logic [3:0] wbwr);
    push(1'b1, ins, af, 4'd0, 4'd0, 4'b1100, 2'b00);
    push(1'b1, ins, af, 4'd1, 4'd1, 4'b0000, 2'b00);
    push(1'b1, ins, af, exst, exst, 4'b0000, alu);
    push(1'b1, ins, af, 4'd8, 4'd8, wbwr, 2'b00);
  endtask

  // Branch with a distractor ALUFlags value that must never reach the flags.
  task automatic br(input logic [19:0] ins, input logic taken);
    push(1'b1, ins, 4'hF, 4'd0, 4'd0, 4'b1100, 2'b00);
    push(1'b1, ins, 4'hF, 4'd1, 4'd1, 4'b0000, 2'b00);
    push(1'b1, ins, 4'hF, 4'd9, 4'd9, {taken, 3'b000}, 2'b00);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic step(output obs_t got);
    stim_t s;
    @(posedge clk);
    #1;
    if (stq.size() != 0) begin
      s = stq.pop_front();
      reset    = s.rst;
      Instr    = s.ins;
      ALUFlags = s.af;
    end
    @(negedge clk);
    got = '{st: State, wr: {PCWrite, IRWrite, RegWrite, MemWrite},
            mux: {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB}, alu: ALUControl};
  endtask

  task automatic test_reset();
    obs_t got, e;
    logic [19:0] lst [4];
    logic [19:0] ins;
    logic [1:0]  op;
    lst = '{20'hE2821, 20'hE5910, 20'h0A000, 20'hEC000};
    for (int i = 0; i < 4; i++) begin
      push(1'b0, lst[i], 4'hF, 4'd0, 4'd0, 4'b0000, 2'b00);
      step(got);
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL reset cyc=%0d got st=%0d wr=%b mux=%b alu=%b want st=%0d wr=%b mux=%b alu=%b",
                 i, got.st, got.wr, got.mux, got.alu, e.st, e.wr, e.mux, e.alu);
      end
      ins = lst[i];
      op  = ins[15:14];
      total++;
      if (ImmSrc !== op || RegSrc !== {op == 2'b01, op == 2'b10}) begin
        bad++;
        $display("FAIL immsrc_regsrc instr=%h got ImmSrc=%b RegSrc=%b want ImmSrc=%b RegSrc=%b",
                 ins, ImmSrc, RegSrc, op, {op == 2'b01, op == 2'b10});
      end
    end
  endtask

  task automatic test_add_imm();
    obs_t got, e;
    int   n = 0;
    dp(20'hE2821, 4'hF, 4'd7, 2'b00, 4'b0010);   // ADD R1,R2,#5
    dp(20'hE282F, 4'hF, 4'd7, 2'b00, 4'b1010);   // ADD PC,R2,#5 writes the PC in ALUWB
    while (sb.size() != 0) begin
      step(got); e = sb.pop_front(); total++;
      if (got !== e) begin
        bad++;
        $display("FAIL add_imm cyc=%0d got st=%0d wr=%b mux=%b alu=%b want st=%0d wr=%b mux=%b alu=%b",
                 n, got.st, got.wr, got.mux, got.alu, e.st, e.wr, e.mux, e.alu);
      end
      n++;
    end
  endtask

  task automatic test_exec_reg();
    obs_t got, e;
    int   n = 0;
    dp(20'hE1821, 4'hF, 4'd6, 2'b11, 4'b0010);   // ORR R1,R2,R?
    dp(20'hE0021, 4'hF, 4'd6, 2'b10, 4'b0010);   // AND
    while (sb.size() != 0) begin
      step(got); e = sb.pop_front(); total++;
      if (got !== e) begin
        bad++;
        $display("FAIL exec_reg cyc=%0d got st=%0d wr=%b mux=%b alu=%b want st=%0d wr=%b mux=%b alu=%b",
                 n, got.st, got.wr, got.mux, got.alu, e.st, e.wr, e.mux, e.alu);
      end
      n++;
    end
  endtask

  task automatic test_flags_branch();
    obs_t got, e;
    int   n = 0;
    dp(20'hE2522, 4'b0100, 4'd7, 2'b01, 4'b0010); // SUBS sets Z
    br(20'h0A000, 1'b1);                          // BEQ taken
    br(20'h1A000, 1'b0);                          // BNE not taken
    while (sb.size() != 0) begin
      step(got); e = sb.pop_front(); total++;
      if (got !== e) begin
        bad++;
        $display("FAIL flags_branch cyc=%0d got st=%0d wr=%b mux=%b alu=%b want st=%0d wr=%b mux=%b alu=%b",
                 n, got.st, got.wr, got.mux, got.alu, e.st, e.wr, e.mux, e.alu);
      end
      n++;
    end
  endtask

  task automatic test_mem();
    obs_t got, e;
    int   n = 0;
    // Op=11 no-op: FETCH, DECODE, then straight back to FETCH
    push(1'b1, 20'hEC000, 4'hF, 4'd0, 4'd0, 4'b1100, 2'b00);
    push(1'b1, 20'hEC000, 4'hF, 4'd1, 4'd1, 4'b0000, 2'b00);
    // LDR R0,[R1,#4]
    push(1'b1, 20'hE5910, 4'hF, 4'd0, 4'd0, 4'b1100, 2'b00);
    push(1'b1, 20'hE5910, 4'hF, 4'd1, 4'd1, 4'b0000, 2'b00);
    push(1'b1, 20'hE5910, 4'hF, 4'd2, 4'd2, 4'b0000, 2'b00);
    push(1'b1, 20'hE5910, 4'hF, 4'd3, 4'd3, 4'b0000, 2'b00);
    push(1'b1, 20'hE5910, 4'hF, 4'd4, 4'd4, 4'b0010, 2'b00);
    // STR R0,[R1,#4]
    push(1'b1, 20'hE5810, 4'hF, 4'd0, 4'd0, 4'b1100, 2'b00);
    push(1'b1, 20'hE5810, 4'hF, 4'd1, 4'd1, 4'b0000, 2'b00);
    push(1'b1, 20'hE5810, 4'hF, 4'd2, 4'd2, 4'b0000, 2'b00);
    push(1'b1, 20'hE5810, 4'hF, 4'd5, 4'd5, 4'b0001, 2'b00);
    while (sb.size() != 0) begin
      step(got); e = sb.pop_front(); total++;
      if (got !== e) begin
        bad++;
        $display("FAIL mem cyc=%0d got st=%0d wr=%b mux=%b alu=%b want st=%0d wr=%b mux=%b alu=%b",
                 n, got.st, got.wr, got.mux, got.alu, e.st, e.wr, e.mux, e.alu);
      end
      n++;
    end
  endtask

  task automatic test_cond_fail();
    obs_t got, e;
    int   n = 0;
    dp(20'h12921, 4'b1000, 4'd7, 2'b00, 4'b0000); // ADDSNE with Z=1: nothing written
    br(20'h0A000, 1'b1);                          // Z still set
    br(20'h4A000, 1'b0);                          // N never took the 1000
    while (sb.size() != 0) begin
      step(got); e = sb.pop_front(); total++;
      if (got !== e) begin
        bad++;
        $display("FAIL cond_fail cyc=%0d got st=%0d wr=%b mux=%b alu=%b want st=%0d wr=%b mux=%b alu=%b",
                 n, got.st, got.wr, got.mux, got.alu, e.st, e.wr, e.mux, e.alu);
      end
      n++;
    end
  endtask

  task automatic test_flag_enables();
    obs_t got, e;
    int   n = 0;
    dp(20'hE2921, 4'b0011, 4'd7, 2'b00, 4'b0010); // ADDS: NZCV <- 0011
    br(20'h2A000, 1'b1);                          // BCS
    br(20'h6A000, 1'b1);                          // BVS
    br(20'h0A000, 1'b0);                          // BEQ
    dp(20'hE3921, 4'b1000, 4'd7, 2'b11, 4'b0010); // ORRS: only NZ move -> 1011
    br(20'h4A000, 1'b1);                          // BMI
    br(20'h2A000, 1'b1);                          // BCS, C kept
    dp(20'hE3F21, 4'b0100, 4'd7, 2'b00, 4'b0010); // unknown cmd: add, flags held
    br(20'h0A000, 1'b0);                          // BEQ, Z not set
    br(20'h6A000, 1'b1);                          // BVS, V kept
    while (sb.size() != 0) begin
      step(got); e = sb.pop_front(); total++;
      if (got !== e) begin
        bad++;
        $display("FAIL flag_enables cyc=%0d got st=%0d wr=%b mux=%b alu=%b want st=%0d wr=%b mux=%b alu=%b",
                 n, got.st, got.wr, got.mux, got.alu, e.st, e.wr, e.mux, e.alu);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, e;
    int   n = 0;
    push(1'b1, 20'hE5810, 4'hF, 4'd0, 4'd0, 4'b1100, 2'b00);
    push(1'b1, 20'hE5810, 4'hF, 4'd1, 4'd1, 4'b0000, 2'b00);
    push(1'b1, 20'hE5810, 4'hF, 4'd2, 4'd2, 4'b0000, 2'b00);
    // reset lands in MEMWR: state still shows 5, muxes FETCH, no writes
    push(1'b0, 20'hE5810, 4'hF, 4'd5, 4'd0, 4'b0000, 2'b00);
    push(1'b1, 20'hE5810, 4'hF, 4'd0, 4'd0, 4'b1100, 2'b00);
    push(1'b1, 20'hE5810, 4'hF, 4'd1, 4'd1, 4'b0000, 2'b00);
    push(1'b1, 20'hE5810, 4'hF, 4'd2, 4'd2, 4'b0000, 2'b00);
    push(1'b1, 20'hE5810, 4'hF, 4'd5, 4'd5, 4'b0001, 2'b00);
    br(20'h2A000, 1'b0);                          // C cleared
    br(20'h4A000, 1'b0);                          // N cleared
    br(20'h6A000, 1'b0);                          // V cleared
    br(20'h1A000, 1'b1);                          // Z cleared
    while (sb.size() != 0) begin
      step(got); e = sb.pop_front(); total++;
      if (got !== e) begin
        bad++;
        $display("FAIL reset_mid cyc=%0d got st=%0d wr=%b mux=%b alu=%b want st=%0d wr=%b mux=%b alu=%b",
                 n, got.st, got.wr, got.mux, got.alu, e.st, e.wr, e.mux, e.alu);
      end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_add_imm();
    test_exec_reg();
    test_flags_branch();
    test_mem();
    test_cond_fail();
    test_flag_enables();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
